// File: rtl/nbody_pkg.sv
// rtl/nbody_pkg.sv - shared types and default latencies for the n-body step sequencer
package nbody_pkg;

  localparam int DEF_BODIES          = 512;
  localparam int DEF_MULT_LATENCY    = 8;
  localparam int DEF_ADD_LATENCY     = 20;
  localparam int DEF_INVSQRT_LATENCY = 30;
  localparam int DEF_ACCL_LATENCY    = 123;

  typedef enum logic [1:0] {
    PHASE_IDLE  = 2'd0,
    PHASE_ACCEL = 2'd1,
    PHASE_POS   = 2'd2
  } phase_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_ACCEL_DRAIN,
    S_POS,
    S_POS_DRAIN,
    S_DONE
  } state_t;

  function automatic phase_t phase_of(input state_t s);
    case (s)
      S_ACCEL, S_ACCEL_DRAIN: phase_of = PHASE_ACCEL;
      S_POS, S_POS_DRAIN:     phase_of = PHASE_POS;
      default:                phase_of = PHASE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/nbody_delay_line.sv
// rtl/nbody_delay_line.sv - valid+payload shift register with synchronous clear
module nbody_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
      end
    end else if (clr_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/nbody_step_sequencer.sv
// rtl/nbody_step_sequencer.sv - step scheduler: pair reads, latency-matched valids, position updates
module nbody_step_sequencer
  import nbody_pkg::*;
#(
  parameter int BODIES          = DEF_BODIES,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int ACCL_LATENCY    = DEF_ACCL_LATENCY,
  parameter int ADD_LATENCY     = DEF_ADD_LATENCY,
  parameter int STEP_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [BODY_ADDR_WIDTH:0]   num_bodies,
  input  logic [STEP_WIDTH-1:0]      num_steps,
  input  logic                       done_ack,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 phase,
  output logic                       first_step,
  output logic                       rd_valid,
  output logic [BODY_ADDR_WIDTH-1:0] rd_i,
  output logic [BODY_ADDR_WIDTH-1:0] rd_j,
  output logic                       rd_self,
  output logic                       acc_valid,
  output logic [BODY_ADDR_WIDTH-1:0] acc_i,
  output logic [BODY_ADDR_WIDTH-1:0] acc_j,
  output logic                       acc_self,
  output logic                       acc_last,
  output logic                       pos_rd_valid,
  output logic [BODY_ADDR_WIDTH-1:0] pos_rd_addr,
  output logic                       pos_wr_en,
  output logic [BODY_ADDR_WIDTH-1:0] pos_wr_addr,
  output logic [STEP_WIDTH-1:0]      step_count
);

  localparam int AW   = BODY_ADDR_WIDTH;
  localparam int NW   = AW + 1;
  localparam int AP_W = 2 * AW + 2;

  state_t                state_q, state_d;
  phase_t                phase_q;
  logic [NW-1:0]         n_q, n_d, n_clamped, n_last;
  logic [STEP_WIDTH-1:0] s_q, s_d, step_q, step_d, step_inc;
  logic                  rd_valid_q, rd_valid_d, rd_self_q, rd_self_d;
  logic [AW-1:0]         rd_i_q, rd_i_d, rd_j_q, rd_j_d, pos_addr_q, pos_addr_d;
  logic                  pos_valid_q, pos_valid_d, first_q, first_d;
  logic                  busy_q, done_q, clr;
  logic                  i_last, j_last, pos_last, acc_done, wr_done;
  logic [AP_W-1:0]       acc_in, acc_out;

  assign n_clamped = (num_bodies > NW'(BODIES)) ? NW'(BODIES) : num_bodies;
  assign n_last    = n_q - NW'(1);
  assign i_last    = ({1'b0, rd_i_q} == n_last);
  assign j_last    = ({1'b0, rd_j_q} == n_last);
  assign pos_last  = ({1'b0, pos_addr_q} == n_last);
  assign acc_done  = acc_valid && acc_last && ({1'b0, acc_i} == n_last);
  assign wr_done   = pos_wr_en && ({1'b0, pos_wr_addr} == n_last);
  assign step_inc  = step_q + STEP_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    s_d         = s_q;
    step_d      = step_q;
    first_d     = first_q;
    rd_valid_d  = 1'b0;
    rd_i_d      = rd_i_q;
    rd_j_d      = rd_j_q;
    pos_valid_d = 1'b0;
    pos_addr_d  = pos_addr_q;
    clr         = 1'b0;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      first_d = 1'b0;
      clr     = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          n_d    = n_clamped;
          s_d    = num_steps;
          step_d = '0;
          if (n_clamped == '0 || num_steps == '0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ACCEL;
            first_d    = 1'b1;
            rd_valid_d = 1'b1;
            rd_i_d     = '0;
            rd_j_d     = '0;
          end
        end
        S_ACCEL: begin
          // j is the inner index; the last pair hands off to the drain.
          if (j_last && i_last) begin
            state_d = S_ACCEL_DRAIN;
          end else if (j_last) begin
            rd_valid_d = 1'b1;
            rd_i_d     = rd_i_q + AW'(1);
            rd_j_d     = '0;
          end else begin
            rd_valid_d = 1'b1;
            rd_j_d     = rd_j_q + AW'(1);
          end
        end
        S_ACCEL_DRAIN: if (acc_done) begin
          state_d     = S_POS;
          pos_valid_d = 1'b1;
          pos_addr_d  = '0;
        end
        S_POS: begin
          if (pos_last) begin
            state_d = S_POS_DRAIN;
          end else begin
            pos_valid_d = 1'b1;
            pos_addr_d  = pos_addr_q + AW'(1);
          end
        end
        S_POS_DRAIN: if (wr_done) begin
          step_d  = step_inc;
          first_d = 1'b0;
          if (step_inc == s_q) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ACCEL;
            rd_valid_d = 1'b1;
            rd_i_d     = '0;
            rd_j_d     = '0;
          end
        end
        S_DONE: if (done_ack) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    rd_self_d = rd_valid_d && (rd_i_d == rd_j_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      phase_q     <= PHASE_IDLE;
      n_q         <= '0;
      s_q         <= '0;
      step_q      <= '0;
      first_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_i_q      <= '0;
      rd_j_q      <= '0;
      rd_self_q   <= 1'b0;
      pos_valid_q <= 1'b0;
      pos_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_of(state_d);
      n_q         <= n_d;
      s_q         <= s_d;
      step_q      <= step_d;
      first_q     <= first_d;
      rd_valid_q  <= rd_valid_d;
      rd_i_q      <= rd_i_d;
      rd_j_q      <= rd_j_d;
      rd_self_q   <= rd_self_d;
      pos_valid_q <= pos_valid_d;
      pos_addr_q  <= pos_addr_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  // Payload is zeroed when not valid so idle delay-line outputs read as 0.
  assign acc_in = rd_valid_q ? {rd_i_q, rd_j_q, rd_self_q, j_last} : '0;

  nbody_delay_line #(.DEPTH(ACCL_LATENCY), .WIDTH(AP_W)) u_acc_line (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (clr),
    .valid_i (rd_valid_q),
    .data_i  (acc_in),
    .valid_o (acc_valid),
    .data_o  (acc_out)
  );

  nbody_delay_line #(.DEPTH(ADD_LATENCY + 1), .WIDTH(AW)) u_pos_line (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (clr),
    .valid_i (pos_valid_q),
    .data_i  (pos_valid_q ? pos_addr_q : '0),
    .valid_o (pos_wr_en),
    .data_o  (pos_wr_addr)
  );

  assign {acc_i, acc_j, acc_self, acc_last} = acc_out;
  assign busy         = busy_q;
  assign done         = done_q;
  assign phase        = phase_q;
  assign first_step   = first_q;
  assign rd_valid     = rd_valid_q;
  assign rd_i         = rd_i_q;
  assign rd_j         = rd_j_q;
  assign rd_self      = rd_self_q;
  assign pos_rd_valid = pos_valid_q;
  assign pos_rd_addr  = pos_addr_q;
  assign step_count   = step_q;

endmodule

// File: doc/nbody_step_sequencer.md
Name: nbody_step_sequencer

Overview:
- Central scheduler for one or more n-body integration steps: start/done handshake, per-step phase control, address and valid generation for the acceleration datapath and the position-update adder.
- Sits between the bus-facing register block and the x/y/m/vx/vy memories, the acceleration pipeline and the AddSub units.
- Replaces ad-hoc timer counting with latency-matched valid delay lines.

Parameters:
- BODIES, 512, maximum body count.
- BODY_ADDR_WIDTH, $clog2(BODIES), body index width.
- ACCL_LATENCY, 123, cycles from a pair's read address to its acceleration result (includes the 1-cycle RAM read).
- ADD_LATENCY, 20, AddSub latency.
- STEP_WIDTH, 16, step counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  pulse; begins a run (accepted only in IDLE).
- abort  in  1  synchronous cancel of a run.
- num_bodies  in  BODY_ADDR_WIDTH+1  body count N (1..BODIES); latched at start.
- num_steps  in  STEP_WIDTH  step count S; latched at start.
- done_ack  in  1  software acknowledge of done.
- busy  out  1  high in any state except IDLE.
- done  out  1  high in DONE.
- phase  out  2  0 = idle/done, 1 = accel, 2 = pos.
- first_step  out  1  high throughout step 0 (half-step velocity kick).
- rd_valid  out  1  pair read issued this cycle.
- rd_i  out  BODY_ADDR_WIDTH  pair read index i.
- rd_j  out  BODY_ADDR_WIDTH  pair read index j.
- rd_self  out  1  i == j; the datapath zeroes the contribution.
- acc_valid  out  1  acceleration result valid (velocity accumulate write).
- acc_i  out  BODY_ADDR_WIDTH  i of the pair whose result is on acc_*.
- acc_j  out  BODY_ADDR_WIDTH  j of that pair.
- acc_self  out  1  rd_self of that pair.
- acc_last  out  1  acc_j == N-1.
- pos_rd_valid  out  1  position/velocity read issued.
- pos_rd_addr  out  BODY_ADDR_WIDTH  position/velocity read address.
- pos_wr_en  out  1  position write enable.
- pos_wr_addr  out  BODY_ADDR_WIDTH  position write address.
- step_count  out  STEP_WIDTH  steps completed in the current run.

Behaviour:
- All outputs are registered.
- Reset (rst=0) forces state IDLE and every output to 0, including the delay-line contents. This applies mid-run as well.
- States: IDLE, ACCEL, ACCEL_DRAIN, POS, POS_DRAIN, DONE.
- IDLE
  - start=1 latches N and S, and clears step_count.
  - If N==0 or S==0: go to DONE.
  - Otherwise: go to ACCEL with first_step=1.
- ACCEL
  - rd_valid=1 for exactly N*N consecutive cycles; the first is the cycle after start is accepted.
  - Order: (i,j) = (0,0),(0,1)..(0,N-1),(1,0)..(N-1,N-1); j is inner.
  - All pairs are issued, including i==j with rd_self=1.
  - After the last pair, go to ACCEL_DRAIN.
- Acceleration delay line
  - acc_valid/acc_i/acc_j/acc_self are rd_valid/rd_i/rd_j/rd_self delayed exactly ACCL_LATENCY cycles.
  - acc_last = acc_valid && acc_j == N-1.
- ACCEL_DRAIN
  - Lasts until the last acc_valid has been emitted.
  - pos_rd_valid first rises the cycle after the final acc_valid.
- POS
  - pos_rd_valid=1 for N consecutive cycles, pos_rd_addr 0..N-1.
  - Then go to POS_DRAIN.
- Position delay line
  - pos_wr_en/pos_wr_addr are pos_rd_valid/pos_rd_addr delayed ADD_LATENCY+1 cycles.
- POS_DRAIN
  - On the cycle of the last pos_wr_en, step_count increments; the new value is visible next cycle.
  - If the new value == S: go to DONE.
  - Otherwise: go to ACCEL with first_step=0; the next rd_valid is the cycle after the last pos_wr_en.
- DONE
  - done=1, busy=1, held until done_ack=1; then IDLE.
  - done_ack in any other state is ignored.
  - start together with done_ack in DONE: ack is taken, start is ignored and must be re-pulsed.
- start while busy is ignored.
- abort=1 in any non-IDLE state:
  - Next state is IDLE.
  - rd_valid, pos_rd_valid, acc_valid, pos_wr_en and both delay lines are cleared the next cycle; no partial writes complete.
  - done is not asserted.
  - step_count holds its value.
  - abort in IDLE is a no-op; abort has priority over start.
- N==1: one self pair per step, one position read/write.
- Counters are wide enough for N*N-1 (2*BODY_ADDR_WIDTH bits) and wrap only at the run boundary.
- num_bodies > BODIES is clamped to BODIES at latch.

Decomposition:
- nbody_pkg holds:
  - the phase_t enum: IDLE=0, ACCEL=1, POS=2;
  - the state enum;
  - the default latency constants MULT/ADD/INVSQRT/ACCL_LATENCY, shared with the acceleration pipeline.
- One sub-module, nbody_delay_line, is natural.
  - Parameters: DEPTH and WIDTH; a valid+payload shift register with clear.
  - It is instantiated twice: depth ACCL_LATENCY and depth ADD_LATENCY+1.

Test Plan:
- Bench overrides: ACCL_LATENCY=4, ADD_LATENCY=2.
- Single step, N=3, S=1, start at cycle 0:
  - rd_valid cycles 1-9, pairs (0,0)..(2,2); rd_self on cycles 1, 5, 9.
  - acc_valid cycles 5-13; acc_last on cycles 7, 10, 13.
  - pos_rd_valid cycles 14-16; pos_wr_en cycles 17-19, addr 0,1,2.
  - done=1 from cycle 20; step_count=1.
- Multi-step, N=2, S=3:
  - first_step=1 only during step 0.
  - step_count steps 1, 2, 3; exactly 12 acc_valid and 6 pos_wr_en pulses.
  - done only after the third step.
- Handshake:
  - done stays high 50 cycles without done_ack, then drops the cycle after done_ack.
  - start during busy is ignored.
  - start together with done_ack in DONE is ignored.
- Abort mid-ACCEL (cycle 6 of the N=3 run):
  - Next cycle: IDLE, busy=0, all valids 0, no further acc_valid or pos_wr_en.
  - done never asserted.
  - A subsequent start runs cleanly from pair (0,0).
- Edge counts:
  - N=0: done next cycle, zero rd_valid.
  - S=0: same as N=0.
  - N=1, S=1: one rd_self pair, one pos write.
- Async reset (rst=0) mid-POS: all outputs 0 immediately, without waiting for a clock edge; state IDLE after release.
